// File: rtl/data_mem_controller.sv
// Round-robin arbiter of per-thread LSU data-memory channels onto one memory port.
// One transaction in flight; four-phase handshake toward consumers, pulse-ready toward memory.
module data_mem_controller #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,

    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data,
    input  logic                     mem_write_ready
);

    localparam int unsigned IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;

    logic                       mem_read_valid_d;
    logic [ADDR_BITS-1:0]       mem_read_address_d;
    logic                       mem_write_valid_d;
    logic [ADDR_BITS-1:0]       mem_write_address_d;
    logic [DATA_BITS-1:0]       mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]   consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0]   consumer_write_ready_d;
    logic [DATA_BITS-1:0]       consumer_read_data_d [NUM_CONSUMERS];

    logic                       found;
    logic [IDX_W-1:0]           cand;
    logic                       release_now;

    // State, pointers and all outputs are registered; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            rr_ptr_q             <= '0;
            grant_idx_q          <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '{default: '0};
        end else begin
            state_q              <= state_d;
            rr_ptr_q             <= rr_ptr_d;
            grant_idx_q          <= grant_idx_d;
            mem_read_valid       <= mem_read_valid_d;
            mem_read_address     <= mem_read_address_d;
            mem_write_valid      <= mem_write_valid_d;
            mem_write_address    <= mem_write_address_d;
            mem_write_data       <= mem_write_data_d;
            consumer_read_ready  <= consumer_read_ready_d;
            consumer_write_ready <= consumer_write_ready_d;
            consumer_read_data   <= consumer_read_data_d;
        end
    end

    // Next-state and next-output logic: round-robin grant, memory wait, consumer release.
    always_comb begin
        state_d                = state_q;
        rr_ptr_d               = rr_ptr_q;
        grant_idx_d            = grant_idx_q;
        mem_read_valid_d       = mem_read_valid;
        mem_read_address_d     = mem_read_address;
        mem_write_valid_d      = mem_write_valid;
        mem_write_address_d    = mem_write_address;
        mem_write_data_d       = mem_write_data;
        consumer_read_ready_d  = consumer_read_ready;
        consumer_write_ready_d = consumer_write_ready;
        consumer_read_data_d   = consumer_read_data;
        found                  = 1'b0;
        cand                   = '0;
        release_now            = 1'b0;

        case (state_q)
            IDLE: begin
                // First requester at or after rr_ptr wins; read beats write on the same channel.
                for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                    if (!found) begin
                        cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_CONSUMERS);
                        if (consumer_read_valid[cand] || consumer_write_valid[cand]) begin
                            found       = 1'b1;
                            grant_idx_d = cand;
                        end
                    end
                end
                if (found) begin
                    if (consumer_read_valid[grant_idx_d]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[grant_idx_d];
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[grant_idx_d];
                        mem_write_data_d    = consumer_write_data[grant_idx_d];
                        state_d             = WRITE_WAIT;
                    end
                end
            end

            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d                   = 1'b0;
                    consumer_read_ready_d[grant_idx_q] = 1'b1;
                    consumer_read_data_d[grant_idx_q]  = mem_read_data;
                    state_d                            = RELAY;
                end
            end

            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d                   = 1'b0;
                    consumer_write_ready_d[grant_idx_q] = 1'b1;
                    state_d                             = RELAY;
                end
            end

            RELAY: begin
                // The raised ready bit tells which valid the granted consumer must drop.
                if (consumer_read_ready[grant_idx_q]) begin
                    release_now = !consumer_read_valid[grant_idx_q];
                end else begin
                    release_now = !consumer_write_valid[grant_idx_q];
                end
                if (release_now) begin
                    consumer_read_ready_d  = '0;
                    consumer_write_ready_d = '0;
                    rr_ptr_d               = IDX_W'((32'(grant_idx_q) + 32'd1) % NUM_CONSUMERS);
                    state_d                = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: transaction table plus reset corner sequence.
module tb_data_mem_controller;

    localparam int unsigned N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] c_rv, c_rr, c_wv, c_wr;
    logic [7:0]   c_ra [N];
    logic [7:0]   c_rd [N];
    logic [7:0]   c_wa [N];
    logic [7:0]   c_wd [N];
    logic         m_rv, m_rr, m_wv, m_wr;
    logic [7:0]   m_ra, m_rd, m_wa, m_wd;

    int           n_vec;
    int           n_err;
    logic [7:0]   exp_rd [N];

    // rmask/wmask: requests newly raised; the rest describes the grant expected next.
    typedef struct {
        logic [3:0] rmask;
        logic [3:0] wmask;
        int         ch;
        bit         rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         lat;
        int         hold;
    } vec_t;

    vec_t vecs [18];

    data_mem_controller #(
        .ADDR_BITS    (8),
        .DATA_BITS    (8),
        .NUM_CONSUMERS(N)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (c_rv),
        .consumer_read_address (c_ra),
        .consumer_read_ready   (c_rr),
        .consumer_read_data    (c_rd),
        .consumer_write_valid  (c_wv),
        .consumer_write_address(c_wa),
        .consumer_write_data   (c_wd),
        .consumer_write_ready  (c_wr),
        .mem_read_valid        (m_rv),
        .mem_read_address      (m_ra),
        .mem_read_ready        (m_rr),
        .mem_read_data         (m_rd),
        .mem_write_valid       (m_wv),
        .mem_write_address     (m_wa),
        .mem_write_data        (m_wd),
        .mem_write_ready       (m_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_data();
        for (int c = 0; c < int'(N); c++) begin
            chk($sformatf("consumer_read_data[%0d]", c), 32'(c_rd[c]), 32'(exp_rd[c]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_read_valid"},    32'(m_rv), 32'd0);
        chk({tag, "_mem_read_address"},  32'(m_ra), 32'd0);
        chk({tag, "_mem_write_valid"},   32'(m_wv), 32'd0);
        chk({tag, "_mem_write_address"}, 32'(m_wa), 32'd0);
        chk({tag, "_mem_write_data"},    32'(m_wd), 32'd0);
        chk({tag, "_consumer_readies"},  32'({c_rr, c_wr}), 32'd0);
        check_data();
    endtask

    // Waits for the grant, checks the memory request, answers it, and runs the consumer release.
    task automatic serve(input vec_t v);
        int         waited;
        logic [7:0] saved_a;
        logic [7:0] saved_d;
        logic [31:0] onehot;
        waited = 0;
        onehot = 32'd1 << v.ch;
        while (!(m_rv || m_wv) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("grant_latency", 32'(waited), 32'd1);
        if (v.rd) begin
            chk("mem_read_valid",       32'(m_rv), 32'd1);
            chk("mem_write_valid_idle", 32'(m_wv), 32'd0);
            chk("mem_read_address",     32'(m_ra), 32'(v.addr));
        end else begin
            chk("mem_write_valid",     32'(m_wv), 32'd1);
            chk("mem_read_valid_idle", 32'(m_rv), 32'd0);
            chk("mem_write_address",   32'(m_wa), 32'(v.addr));
            chk("mem_write_data",      32'(m_wd), 32'(v.wdata));
        end
        chk("consumer_ready_before_mem", 32'({c_rr, c_wr}), 32'd0);

        // Scramble the granted consumer's inputs while waiting; memory side must not follow.
        saved_a = v.rd ? c_ra[v.ch] : c_wa[v.ch];
        saved_d = c_wd[v.ch];
        if (v.lat > 0) begin
            if (v.rd) c_ra[v.ch] = ~saved_a;
            else begin
                c_wa[v.ch] = ~saved_a;
                c_wd[v.ch] = ~saved_d;
            end
        end
        repeat (v.lat) begin
            @(posedge clk); #1;
            if (v.rd) begin
                chk("wait_read_valid",   32'(m_rv), 32'd1);
                chk("wait_read_address", 32'(m_ra), 32'(v.addr));
            end else begin
                chk("wait_write_valid",   32'(m_wv), 32'd1);
                chk("wait_write_address", 32'(m_wa), 32'(v.addr));
                chk("wait_write_data",    32'(m_wd), 32'(v.wdata));
                chk("wait_no_read",       32'(m_rv), 32'd0);
            end
            chk("wait_consumer_ready", 32'({c_rr, c_wr}), 32'd0);
        end
        if (v.rd) c_ra[v.ch] = saved_a;
        else begin
            c_wa[v.ch] = saved_a;
            c_wd[v.ch] = saved_d;
        end

        if (v.rd) begin
            m_rr = 1'b1;
            m_rd = v.rdata;
        end else begin
            m_wr = 1'b1;
        end
        @(posedge clk); #1;
        m_rr = 1'b0;
        m_wr = 1'b0;
        m_rd = ~v.rdata;
        if (v.rd) begin
            exp_rd[v.ch] = v.rdata;
            chk("consumer_read_ready",      32'(c_rr), onehot);
            chk("consumer_write_ready_off", 32'(c_wr), 32'd0);
            chk("mem_read_valid_dropped",   32'(m_rv), 32'd0);
        end else begin
            chk("consumer_write_ready",     32'(c_wr), onehot);
            chk("consumer_read_ready_off",  32'(c_rr), 32'd0);
            chk("mem_write_valid_dropped",  32'(m_wv), 32'd0);
        end
        check_data();

        repeat (v.hold) begin
            @(posedge clk); #1;
            chk("relay_ready_held", 32'(v.rd ? c_rr : c_wr), onehot);
            chk("relay_no_grant",   32'({m_rv, m_wv}), 32'd0);
        end

        if (v.rd) c_rv[v.ch] = 1'b0;
        else      c_wv[v.ch] = 1'b0;
        @(posedge clk); #1;
        chk("ready_released",        32'({c_rr, c_wr}), 32'd0);
        chk("no_mem_req_on_release", 32'({m_rv, m_wv}), 32'd0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (vecs[i].rmask[c]) c_rv[c] = 1'b1;
                if (vecs[i].wmask[c]) c_wv[c] = 1'b1;
            end
            serve(vecs[i]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        c_rv  = '0;
        c_wv  = '0;
        m_rr  = 1'b0;
        m_wr  = 1'b0;
        m_rd  = '0;
        c_ra[0] = 8'h30; c_ra[1] = 8'h31; c_ra[2] = 8'h10; c_ra[3] = 8'h33;
        c_wd[0] = 8'h55; c_wd[1] = 8'h66; c_wd[2] = 8'h77; c_wd[3] = 8'h88;
        for (int c = 0; c < int'(N); c++) begin
            c_wa[c]   = 8'h20 + 8'(c);
            exp_rd[c] = 8'h00;
        end

        //              rmask    wmask    ch rd   addr   wdata  rdata lat hold
        vecs[0]  = '{4'b0100, 4'b0000, 2, 1'b1, 8'h10, 8'h00, 8'hAB, 2, 0};
        vecs[1]  = '{4'b0000, 4'b0001, 0, 1'b0, 8'h20, 8'h55, 8'h00, 1, 0};
        vecs[2]  = '{4'b1000, 4'b0000, 3, 1'b1, 8'h33, 8'h00, 8'h3C, 0, 0};
        vecs[3]  = '{4'b1111, 4'b0000, 0, 1'b1, 8'h30, 8'h00, 8'hC0, 0, 0};
        vecs[4]  = '{4'b0000, 4'b0000, 1, 1'b1, 8'h31, 8'h00, 8'hC1, 1, 0};
        vecs[5]  = '{4'b0000, 4'b0000, 2, 1'b1, 8'h10, 8'h00, 8'hC2, 0, 0};
        vecs[6]  = '{4'b0000, 4'b0000, 3, 1'b1, 8'h33, 8'h00, 8'hC3, 3, 0};
        vecs[7]  = '{4'b1001, 4'b0000, 0, 1'b1, 8'h30, 8'h00, 8'hD0, 0, 0};
        vecs[8]  = '{4'b0000, 4'b0000, 3, 1'b1, 8'h33, 8'h00, 8'hD3, 0, 0};
        vecs[9]  = '{4'b0010, 4'b0000, 1, 1'b1, 8'h31, 8'h00, 8'hE1, 0, 0};
        vecs[10] = '{4'b1010, 4'b0000, 3, 1'b1, 8'h33, 8'h00, 8'hE3, 0, 0};
        vecs[11] = '{4'b0000, 4'b0000, 1, 1'b1, 8'h31, 8'h00, 8'hF1, 0, 0};
        vecs[12] = '{4'b0010, 4'b0010, 1, 1'b1, 8'h31, 8'h00, 8'h5A, 0, 0};
        vecs[13] = '{4'b0000, 4'b0000, 1, 1'b0, 8'h21, 8'h66, 8'h00, 0, 0};
        vecs[14] = '{4'b0101, 4'b0000, 2, 1'b1, 8'h10, 8'h00, 8'h77, 0, 5};
        vecs[15] = '{4'b0000, 4'b0000, 0, 1'b1, 8'h30, 8'h00, 8'h07, 1, 0};
        vecs[16] = '{4'b0011, 4'b0000, 0, 1'b1, 8'h30, 8'h00, 8'hA0, 0, 0};
        vecs[17] = '{4'b0000, 4'b0000, 1, 1'b1, 8'h31, 8'h00, 8'hA1, 0, 0};

        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");

        run_rows(0, 15);

        // Reset while a read is outstanding; a late memory ready must be ignored.
        c_rv[1] = 1'b1;
        @(posedge clk); #1;
        chk("midop_mem_read_valid",   32'(m_rv), 32'd1);
        chk("midop_mem_read_address", 32'(m_ra), 32'h31);
        @(posedge clk); #1;
        chk("midop_still_waiting", 32'(m_rv), 32'd1);
        #2 reset = 1'b1;
        #1;
        for (int c = 0; c < int'(N); c++) exp_rd[c] = 8'h00;
        check_all_zero("midop_reset");
        c_rv = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rr  = 1'b1;
        m_wr  = 1'b1;
        m_rd  = 8'h99;
        @(posedge clk); #1;
        m_rr = 1'b0;
        m_wr = 1'b0;
        chk("stray_ready_no_consumer_ready", 32'({c_rr, c_wr}), 32'd0);
        chk("stray_ready_no_mem_req",        32'({m_rv, m_wv}), 32'd0);
        check_data();
        @(posedge clk); #1;
        check_all_zero("after_stray");

        run_rows(16, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
